// File: rtl/rs232_image_tx.sv
// rs232_image_tx: streams the low byte of SRAM words 0..NUM_PIXELS-1 to the RS232 UART over Avalon-MM.
// Optional build macro TX_CHECKSUM_EN appends one XOR checksum byte after the last pixel.
module rs232_image_tx #(
    parameter int unsigned NUM_PIXELS  = 307200,
    parameter int unsigned TX_BASE     = 4,
    parameter int unsigned STATUS_BASE = 8,
    parameter int unsigned TX_OK_BIT   = 6
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    output logic [19:0] o_sram_addr,
    input  logic [15:0] i_sram_dq
);
    localparam logic [19:0] LAST = 20'(NUM_PIXELS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_LATCH, S_POLL, S_WAIT, S_SEND, S_DONE
`ifdef TX_CHECKSUM_EN
        , S_CKPOLL, S_CKWAIT, S_CKSEND
`endif
    } state_t;

`ifdef TX_CHECKSUM_EN
    localparam state_t S_END = S_CKPOLL;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_count;
    logic [7:0]  r_byte;
    logic [7:0]  w_tx_byte;
    logic        w_unused;

    assign o_sram_addr = r_count;
    assign w_unused    = ^{avm_readdata, i_sram_dq[15:8]};

`ifdef TX_CHECKSUM_EN
    logic [7:0] r_ck;
    assign w_tx_byte = (r_state == S_CKSEND) ? r_ck : r_byte;

    // running XOR of every accepted pixel byte, cleared when a frame starts
    always_ff @(posedge avm_clk) begin
        if (avm_rst || (r_state == S_IDLE && i_start)) r_ck <= '0;
        else if (r_state == S_SEND && !avm_waitrequest) r_ck <= r_ck ^ r_byte;
    end
`else
    assign w_tx_byte = r_byte;
`endif

    // state, pixel counter and latched pixel byte
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_start) r_count <= '0;
            else if (r_state == S_SEND && !avm_waitrequest && r_count != LAST) r_count <= r_count + 20'd1;
            if (r_state == S_LATCH) r_byte <= i_sram_dq[7:0];
        end
    end

    // next state and Avalon/handshake outputs; requests are held until waitrequest drops
    always_comb begin
        w_next        = r_state;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_ADDR;
            end
            S_ADDR:  w_next = S_LATCH;
            S_LATCH: w_next = S_POLL;
            S_POLL: begin
                avm_read    = 1'b1;
                avm_address = 5'(STATUS_BASE);
                if (!avm_waitrequest) w_next = avm_readdata[TX_OK_BIT] ? S_SEND : S_WAIT;
            end
            S_WAIT: w_next = S_POLL;
            S_SEND: begin
                avm_write     = 1'b1;
                avm_address   = 5'(TX_BASE);
                avm_writedata = {24'b0, w_tx_byte};
                if (!avm_waitrequest) w_next = (r_count == LAST) ? S_END : S_ADDR;
            end
`ifdef TX_CHECKSUM_EN
            S_CKPOLL: begin
                avm_read    = 1'b1;
                avm_address = 5'(STATUS_BASE);
                if (!avm_waitrequest) w_next = avm_readdata[TX_OK_BIT] ? S_CKSEND : S_CKWAIT;
            end
            S_CKWAIT: w_next = S_CKPOLL;
            S_CKSEND: begin
                avm_write     = 1'b1;
                avm_address   = 5'(TX_BASE);
                avm_writedata = {24'b0, w_tx_byte};
                if (!avm_waitrequest) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule
